// File: rtl/sf2000_pkg.sv
// Shared definitions for the SF2000 Zorro II RAM path: FSM encoding, window sizes, parameter checks.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package sf2000_pkg;

  // Bus-cycle FSM of the Fast RAM controller.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_WAIT = 2'd2,
    ST_ACK  = 2'd3
  } ram_state_t;

  // Board size expressed in 2 MB chunks.
  // This matches the granularity of BASE_RAM (A23..A21).
  localparam logic [2:0] CHUNKS_4MB = 3'd2;
  localparam logic [2:0] CHUNKS_8MB = 3'd4;

  // Wait states fit the 3-bit wait counter.
  localparam int WAIT_STATES_MIN = 0;
  localparam int WAIT_STATES_MAX = 7;

  function automatic bit wait_states_ok(input int ws);
    return (ws >= WAIT_STATES_MIN) && (ws <= WAIT_STATES_MAX);
  endfunction

endpackage

// File: rtl/zii_ram_decode.sv
// Combinational Zorro II window decode: claims a 68000 cycle that falls in the 4/8 MB window at BASE_RAM.
// Latency: 0 (pure combinational).
// Backpressure: none; hit qualifies only while AS_n is low and the base is configured.
// Ports: A[23:1] CPU address, BASE_RAM A23..A21 base, RAM_CONFIGURED_n base-valid (low),
//        AS_n address strobe, JP4 board size (1 = 8 MB) -> hit, sram_a (22-bit word address).
module zii_ram_decode
  import sf2000_pkg::*;
(
  input  logic [23:1] A,
  input  logic [2:0]  BASE_RAM,
  input  logic        RAM_CONFIGURED_n,
  input  logic        AS_n,
  input  logic        JP4,
  output logic        hit,
  output logic [21:0] sram_a
);

  logic [2:0] off;
  logic [2:0] chunks;

  always_comb begin
    // The subtraction is modulo 8 on purpose.
    // A window placed near the top of the map wraps through zero.
    // The "off < chunks" compare still rejects anything outside the board.
    off    = A[23:21] - BASE_RAM;
    chunks = JP4 ? CHUNKS_8MB : CHUNKS_4MB;
    hit    = !RAM_CONFIGURED_n && !AS_n && (off < chunks);
    // In 4 MB mode a hit implies off[1] == 0, so the upper SRAM half is never addressed.
    sram_a = {off[1:0], A[20:1]};
  end

endmodule

// File: rtl/zii_fastram_ctrl.sv
// Zorro II Fast RAM controller: decodes 68000 cycles into the autoconfigured window, drives async SRAM + data buffers.
// Latency: DTACK_n falls WAIT_STATES+2 C7M edges after the hit is sampled (writes also wait for a data strobe).
// Backpressure: the CPU is held by withholding DTACK_n; every cycle ends (or aborts) when AS_CPU_n is sampled high.
// Ports: C7M clock, RESET async active-high; AS_CPU_n/UDS_n/LDS_n/RW_n/A[23:1] CPU bus;
//        BASE_RAM/RAM_CONFIGURED_n/JP4 from autoconfig; DTACK_n, RAM_ACCESS, SRAM_* controls, DBUF_OE_n/DBUF_DIR buffers.
module zii_fastram_ctrl
  import sf2000_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic        C7M,
  input  logic        RESET,
  input  logic        AS_CPU_n,
  input  logic        UDS_n,
  input  logic        LDS_n,
  input  logic        RW_n,
  input  logic [23:1] A,
  input  logic [2:0]  BASE_RAM,
  input  logic        RAM_CONFIGURED_n,
  input  logic        JP4,
  output logic        DTACK_n,
  output logic        RAM_ACCESS,
  output logic [21:0] SRAM_A,
  output logic        SRAM_CE_n,
  output logic        SRAM_OE_n,
  output logic        SRAM_WE_n,
  output logic        SRAM_UB_n,
  output logic        SRAM_LB_n,
  output logic        DBUF_OE_n,
  output logic        DBUF_DIR
);

  generate
    if (!wait_states_ok(WAIT_STATES)) begin : g_bad_wait_states
      $error("zii_fastram_ctrl: WAIT_STATES must be within 0..7");
    end
  endgenerate

  localparam logic [2:0] WS_LOAD = WAIT_STATES[2:0];

  logic        dec_hit;
  logic [21:0] dec_sram_a;

  zii_ram_decode u_decode (
    .A                (A),
    .BASE_RAM         (BASE_RAM),
    .RAM_CONFIGURED_n (RAM_CONFIGURED_n),
    .AS_n             (AS_CPU_n),
    .JP4              (JP4),
    .hit              (dec_hit),
    .sram_a           (dec_sram_a)
  );

  ram_state_t state;
  logic [2:0] wait_cnt;
  logic       ds_low;

  assign ds_low = !UDS_n || !LDS_n;

  always_ff @(posedge C7M or posedge RESET) begin
    if (RESET) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      DTACK_n    <= 1'b1;
      RAM_ACCESS <= 1'b0;
      SRAM_A     <= '0;
      SRAM_CE_n  <= 1'b1;
      SRAM_OE_n  <= 1'b1;
      SRAM_WE_n  <= 1'b1;
      SRAM_UB_n  <= 1'b1;
      SRAM_LB_n  <= 1'b1;
      DBUF_OE_n  <= 1'b1;
      DBUF_DIR   <= 1'b1;
    end else if ((state != ST_IDLE) && AS_CPU_n) begin
      // AS high ends the cycle from any active state.
      // In ACK this is the normal termination.
      // In SEL/WAIT it is an abort, and DTACK_n has not been driven yet.
      // SRAM_A keeps its last value; it is qualified by SRAM_CE_n anyway.
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      DTACK_n    <= 1'b1;
      RAM_ACCESS <= 1'b0;
      SRAM_CE_n  <= 1'b1;
      SRAM_OE_n  <= 1'b1;
      SRAM_WE_n  <= 1'b1;
      SRAM_UB_n  <= 1'b1;
      SRAM_LB_n  <= 1'b1;
      DBUF_OE_n  <= 1'b1;
      DBUF_DIR   <= 1'b1;
    end else begin
      // Byte lanes and the write strobe follow the data strobes every cycle.
      // On 68000 writes, UDS/LDS only arrive after AS.
      if (state != ST_IDLE) begin
        SRAM_UB_n <= UDS_n;
        SRAM_LB_n <= LDS_n;
        SRAM_WE_n <= !(!RW_n && ds_low);
      end

      case (state)
        ST_IDLE: begin
          if (dec_hit) begin
            state      <= ST_SEL;
            RAM_ACCESS <= 1'b1;
            SRAM_A     <= dec_sram_a;
            SRAM_CE_n  <= 1'b0;
            SRAM_OE_n  <= !RW_n;
            DBUF_OE_n  <= 1'b0;
            DBUF_DIR   <= RW_n;
          end
        end

        ST_SEL: begin
          wait_cnt <= WS_LOAD;
          state    <= (WS_LOAD != 3'd0) ? ST_WAIT : ST_ACK;
        end

        ST_WAIT: begin
          if (wait_cnt == 3'd1) begin
            // A write with no data strobe yet parks here with the counter at 1.
            if (RW_n || ds_low) begin
              state    <= ST_ACK;
              wait_cnt <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end

        ST_ACK: begin
          DTACK_n <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zii_fastram_ctrl.sv
// Self-checking bench for zii_fastram_ctrl.
// Two instances share one bus: WAIT_STATES=1 (dut) and 3 (dut3).
// Expectations come from a byte-address window model and edge-count latency rules.
module tb_zii_fastram_ctrl;

  logic        C7M = 1'b0;
  logic        RESET;
  logic        AS_CPU_n, UDS_n, LDS_n, RW_n;
  logic [23:1] A;
  logic [2:0]  BASE_RAM;
  logic        RAM_CONFIGURED_n, JP4;

  logic        DTACK_n, RAM_ACCESS, SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_UB_n, SRAM_LB_n, DBUF_OE_n, DBUF_DIR;
  logic [21:0] SRAM_A;
  logic        DTACK_n3, RAM_ACCESS3, SRAM_CE_n3, SRAM_OE_n3, SRAM_WE_n3, SRAM_UB_n3, SRAM_LB_n3, DBUF_OE_n3, DBUF_DIR3;
  logic [21:0] SRAM_A3;

  int total = 0;
  int bad   = 0;
  logic [21:0] last_sram_a;
  logic [21:0] last_sram_a3;

  // Order: DTACK_n, RAM_ACCESS, CE_n, OE_n, WE_n, UB_n, LB_n, DBUF_OE_n, DBUF_DIR
  localparam logic [8:0] IDLE_OUTS = 9'b101111111;

  always #5 C7M = ~C7M;

  zii_fastram_ctrl #(.WAIT_STATES(1)) dut (
    .C7M(C7M), .RESET(RESET), .AS_CPU_n(AS_CPU_n), .UDS_n(UDS_n), .LDS_n(LDS_n), .RW_n(RW_n),
    .A(A), .BASE_RAM(BASE_RAM), .RAM_CONFIGURED_n(RAM_CONFIGURED_n), .JP4(JP4),
    .DTACK_n(DTACK_n), .RAM_ACCESS(RAM_ACCESS), .SRAM_A(SRAM_A), .SRAM_CE_n(SRAM_CE_n),
    .SRAM_OE_n(SRAM_OE_n), .SRAM_WE_n(SRAM_WE_n), .SRAM_UB_n(SRAM_UB_n), .SRAM_LB_n(SRAM_LB_n),
    .DBUF_OE_n(DBUF_OE_n), .DBUF_DIR(DBUF_DIR)
  );

  zii_fastram_ctrl #(.WAIT_STATES(3)) dut3 (
    .C7M(C7M), .RESET(RESET), .AS_CPU_n(AS_CPU_n), .UDS_n(UDS_n), .LDS_n(LDS_n), .RW_n(RW_n),
    .A(A), .BASE_RAM(BASE_RAM), .RAM_CONFIGURED_n(RAM_CONFIGURED_n), .JP4(JP4),
    .DTACK_n(DTACK_n3), .RAM_ACCESS(RAM_ACCESS3), .SRAM_A(SRAM_A3), .SRAM_CE_n(SRAM_CE_n3),
    .SRAM_OE_n(SRAM_OE_n3), .SRAM_WE_n(SRAM_WE_n3), .SRAM_UB_n(SRAM_UB_n3), .SRAM_LB_n(SRAM_LB_n3),
    .DBUF_OE_n(DBUF_OE_n3), .DBUF_DIR(DBUF_DIR3)
  );

  function automatic logic [8:0] outs1();
    return {DTACK_n, RAM_ACCESS, SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_UB_n, SRAM_LB_n, DBUF_OE_n, DBUF_DIR};
  endfunction

  function automatic logic [8:0] outs3();
    return {DTACK_n3, RAM_ACCESS3, SRAM_CE_n3, SRAM_OE_n3, SRAM_WE_n3, SRAM_UB_n3, SRAM_LB_n3, DBUF_OE_n3, DBUF_DIR3};
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge C7M);
    #1;
  endtask

  // Window model in byte addresses.
  // The board occupies [base*2MB, base*2MB + size), wrapping modulo 16 MB.
  function automatic void model(input logic [23:0] addr, output bit h, output logic [21:0] sa);
    logic [31:0] base_b, size, rel;
    base_b = 32'(BASE_RAM) * 32'h0020_0000;
    size   = JP4 ? 32'h0080_0000 : 32'h0040_0000;
    rel    = (32'(addr) + 32'h0100_0000 - base_b) % 32'h0100_0000;
    h      = !RAM_CONFIGURED_n && (rel < size);
    sa     = rel[22:1];
  endfunction

  // Read cycle.
  // dut must assert DTACK_n 3 edges after the hit edge (edge 0).
  // When long=1, AS is held until dut3 acknowledges (5 edges).
  // Otherwise AS rises while dut3 is still in WAIT, which must abort it.
  task automatic read_cycle(input logic [23:0] addr, input bit uds, input bit lds, input bit long_c,
                            input bit drop_cfg, input string tag);
    bit eh;
    logic [21:0] ea;
    int n1, n3;
    model(addr, eh, ea);
    A = addr[23:1]; RW_n = 1'b1; UDS_n = uds; LDS_n = lds; AS_CPU_n = 1'b0;
    n1 = -1; n3 = -1;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (e == 0) begin
        chk({tag, ":access"}, 32'(RAM_ACCESS), 32'(eh));
        chk({tag, ":access3"}, 32'(RAM_ACCESS3), 32'(eh));
        if (eh) begin
          chk({tag, ":ctl"}, 32'({SRAM_CE_n, SRAM_OE_n, DBUF_OE_n, DBUF_DIR}), 32'(4'b0001));
          chk({tag, ":sram_a"}, 32'(SRAM_A), 32'(ea));
          last_sram_a = ea;
          last_sram_a3 = ea;
        end
        if (drop_cfg) RAM_CONFIGURED_n = 1'b1;
      end
      if (!eh) begin
        chk({tag, ":quiet"}, 32'(outs1()), 32'(IDLE_OUTS));
        chk({tag, ":quiet_a"}, 32'(SRAM_A), 32'(last_sram_a));
        chk({tag, ":quiet3"}, 32'(outs3()), 32'(IDLE_OUTS));
      end
      if (n1 < 0 && !DTACK_n) begin
        n1 = e;
        chk({tag, ":lanes"}, 32'({SRAM_UB_n, SRAM_LB_n, SRAM_WE_n, SRAM_OE_n}), 32'({uds, lds, 2'b10}));
      end
      if (n3 < 0 && !DTACK_n3) n3 = e;
      if (long_c ? (n3 >= 0) : (n1 >= 0)) break;
      if (!eh && e == 6) break;
    end
    chk({tag, ":lat"}, 32'(n1), eh ? 32'd3 : 32'hFFFF_FFFF);
    chk({tag, ":lat3"}, 32'(n3), (eh && long_c) ? 32'd5 : 32'hFFFF_FFFF);
    if (eh && long_c) chk({tag, ":held"}, 32'(DTACK_n), 32'd0);
    AS_CPU_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
    tick();
    chk({tag, ":end"}, 32'(outs1()), 32'(IDLE_OUTS));
    chk({tag, ":end3"}, 32'(outs3()), 32'(IDLE_OUTS));
    chk({tag, ":end_a"}, 32'(SRAM_A), 32'(last_sram_a));
  endtask

  // Write cycle with the data strobe arriving d cycles after AS (d >= 1).
  // ACK needs both the expired wait count and a DS.
  // DTACK_n therefore lands at edge max(3, d+1).
  task automatic write_cycle(input logic [23:0] addr, input bit ub, input bit lb, input int d, input string tag);
    bit eh;
    logic [21:0] ea;
    int n1;
    model(addr, eh, ea);
    A = addr[23:1]; RW_n = 1'b0; UDS_n = 1'b1; LDS_n = 1'b1; AS_CPU_n = 1'b0;
    tick();
    chk({tag, ":access"}, 32'(RAM_ACCESS), 32'(eh));
    chk({tag, ":dir"}, 32'(DBUF_DIR), 32'(!eh));
    if (eh) begin
      chk({tag, ":sram_a"}, 32'(SRAM_A), 32'(ea));
      last_sram_a = ea;
      last_sram_a3 = ea;
    end
    for (int e = 1; e < d; e++) begin
      tick();
      chk({tag, ":no_ds"}, 32'({DTACK_n, SRAM_WE_n, SRAM_OE_n}), 32'(3'b111));
    end
    UDS_n = !ub; LDS_n = !lb;
    n1 = -1;
    for (int e = d; e < d + 10 && n1 < 0; e++) begin
      tick();
      chk({tag, ":oe"}, 32'(SRAM_OE_n), 32'd1);
      if (!DTACK_n) begin
        n1 = e;
        chk({tag, ":lanes"}, 32'({SRAM_WE_n, SRAM_UB_n, SRAM_LB_n}), 32'({1'b0, !ub, !lb}));
      end
    end
    chk({tag, ":lat"}, 32'(n1), eh ? 32'((d + 1 > 3) ? d + 1 : 3) : 32'hFFFF_FFFF);
    AS_CPU_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
    tick();
    RW_n = 1'b1;
    chk({tag, ":end"}, 32'(outs1()), 32'(IDLE_OUTS));
  endtask

  initial begin
    int found;
    logic [23:0] addr;
    logic [31:0] r;
    bit u, l;

    RESET = 1'b1; AS_CPU_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; RW_n = 1'b1;
    A = '0; BASE_RAM = 3'b001; RAM_CONFIGURED_n = 1'b0; JP4 = 1'b1;
    last_sram_a = '0;
    last_sram_a3 = '0;
    tick();
    chk("reset_outs", 32'(outs1()), 32'(IDLE_OUTS));
    chk("reset_sram_a", 32'(SRAM_A), 32'd0);
    chk("reset_outs3", 32'(outs3()), 32'(IDLE_OUTS));
    RESET = 1'b0;
    tick();

    // 8 MB read at the top of the first chunk; dut3 kept to full latency.
    read_cycle(24'h3FFFFE, 1'b0, 1'b0, 1'b1, 1'b0, "rd8");
    chk("rd8_a_val", 32'(last_sram_a), 32'h000F_FFFF);
    // Same read, but AS rises while dut3 sits in WAIT: dut3 must abort silently.
    read_cycle(24'h3FFFFE, 1'b0, 1'b0, 1'b0, 1'b0, "abort3");

    // Window bounds.
    JP4 = 1'b0;
    read_cycle(24'h200000, 1'b0, 1'b1, 1'b0, 1'b0, "b4_lo");
    read_cycle(24'h5FFFFE, 1'b1, 1'b0, 1'b0, 1'b0, "b4_hi");
    read_cycle(24'h600000, 1'b0, 1'b0, 1'b0, 1'b0, "b4_above");
    read_cycle(24'h1FFFFE, 1'b0, 1'b0, 1'b0, 1'b0, "b4_below");
    JP4 = 1'b1;
    read_cycle(24'h9FFFFE, 1'b0, 1'b0, 1'b0, 1'b0, "b8_hi");
    read_cycle(24'hA00000, 1'b0, 1'b0, 1'b0, 1'b0, "b8_above");

    // Writes: the lower lane arrives one cycle after AS, then a later upper-lane write.
    write_cycle(24'h300010, 1'b0, 1'b1, 1, "wr_lb");
    write_cycle(24'h300012, 1'b1, 1'b0, 3, "wr_ub_late");

    // Unconfigured: nothing may move.
    RAM_CONFIGURED_n = 1'b1;
    read_cycle(24'h300000, 1'b0, 1'b0, 1'b0, 1'b0, "unconf");
    RAM_CONFIGURED_n = 1'b0;

    // Losing the configuration mid-cycle lets the running cycle complete.
    read_cycle(24'h240000, 1'b0, 1'b0, 1'b0, 1'b1, "cfg_drop");
    RAM_CONFIGURED_n = 1'b0;

    // Back-to-back reads separated by a single AS-high clock.
    read_cycle(24'h280000, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_1");
    read_cycle(24'h280002, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_2");

    // Reset while dut is in ACK.
    addr = 24'h2A0000;
    A = addr[23:1]; RW_n = 1'b1; UDS_n = 1'b0; LDS_n = 1'b0; AS_CPU_n = 1'b0;
    found = 0;
    for (int e = 0; e < 8 && found == 0; e++) begin
      tick();
      if (!DTACK_n) found = 1;
    end
    chk("rst_reach_ack", 32'(found), 32'd1);
    RESET = 1'b1;
    #1;
    chk("rst_async", 32'({DTACK_n, SRAM_CE_n, RAM_ACCESS}), 32'(3'b110));
    chk("rst_async_outs", 32'(outs1()), 32'(IDLE_OUTS));
    chk("rst_async_a", 32'(SRAM_A), 32'd0);
    chk("rst_async3", 32'(outs3()), 32'(IDLE_OUTS));
    AS_CPU_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
    #1;
    RESET = 1'b0;
    last_sram_a = '0;
    last_sram_a3 = '0;
    tick();
    chk("rst_idle", 32'(outs1()), 32'(IDLE_OUTS));
    read_cycle(24'h2A0000, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst");

    // Randomized cycles against the window model.
    for (int i = 0; i < 40; i++) begin
      JP4 = 1'($urandom_range(0, 1));
      BASE_RAM = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        r = 32'(BASE_RAM) * 32'h0020_0000 + 32'($urandom_range(0, JP4 ? 32'h7F_FFFF : 32'h3F_FFFF));
        addr = r[23:0];
      end else begin
        r = $urandom;
        addr = r[23:0];
      end
      addr[0] = 1'b0;
      u = 1'($urandom_range(0, 1));
      l = u ? 1'b0 : 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        write_cycle(addr, !u, !l, $urandom_range(1, 3), "rnd_wr");
      else
        read_cycle(addr, u, l, 1'($urandom_range(0, 1)), 1'b0, "rnd_rd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
